// File: rtl/div_pkg.sv
// Shared types and constants for the div_sub sequential divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Wide enough for any practical WIDTH; callers truncate to their own width.
  localparam logic [63:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// Combinational trial subtraction: flags r >= d and returns r - d.
// r_hi extends r by one bit; it is set by the shift-subtract datapath.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             r_hi,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] d,
  output logic             ge,
  output logic [WIDTH-1:0] diff
);

  assign ge = r_hi | (r >= d);

  // Whenever ge is set, the true difference fits in WIDTH bits, so the modular result is exact.
  assign diff = r - d;

endmodule

// File: rtl/div_sub.sv
// Sequential unsigned divider with a start/busy/done handshake.
// Define DIV_FAST_EN for fixed-latency restoring division; the default is repeated subtraction.
module div_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div_zero_q, div_zero_d;

  logic             step_hi;
  logic [WIDTH-1:0] step_r;
  logic             step_ge;
  logic [WIDTH-1:0] step_diff;

`ifdef DIV_FAST_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Partial remainder shifted left by one, taking the next dividend bit from the top of Q.
  assign step_hi = r_q[WIDTH-1];
  assign step_r  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
`else
  assign step_hi = 1'b0;
  assign step_r  = r_q;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_hi (step_hi),
    .r    (step_r),
    .d    (d_q),
    .ge   (step_ge),
    .diff (step_diff)
  );

  always_comb begin
    // NOTE: every target gets a hold value first so no path through the case can infer a latch.
    state_d    = state_q;
    r_d        = r_q;
    d_d        = d_q;
    q_d        = q_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
`ifdef DIV_FAST_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          d_d = divisor;
`ifdef DIV_FAST_EN
          r_d   = '0;
          q_d   = dividend;
          cnt_d = '0;
`else
          r_d = dividend;
          q_d = '0;
`endif
          if (divisor == '0) begin
            quot_d     = WIDTH'(ALL_ONES);
            rem_d      = dividend;
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
`ifdef DIV_FAST_EN
        if (cnt_q == CW'(WIDTH)) begin
          quot_d     = q_q;
          rem_d      = r_q;
          div_zero_d = 1'b0;
          state_d    = DONE;
        end else begin
          r_d   = step_ge ? step_diff : step_r;
          q_d   = {q_q[WIDTH-2:0], step_ge};
          cnt_d = cnt_q + 1'b1;
        end
`else
        if (step_ge) begin
          r_d = step_diff;
          q_d = q_q + 1'b1;
        end else begin
          quot_d     = q_q;
          rem_d      = r_q;
          div_zero_d = 1'b0;
          state_d    = DONE;
        end
`endif
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      r_q        <= '0;
      d_q        <= '0;
      q_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
`ifdef DIV_FAST_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      d_q        <= d_d;
      q_q        <= q_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
`ifdef DIV_FAST_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign busy     = (state_q == RUN) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_sub.sv
// Directed self-checking bench for div_sub; expected latencies follow DIV_FAST_EN.
module tb_div_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  localparam int LIMIT = 70000;

  div_sub #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input int q);
`ifdef DIV_FAST_EN
    return 17;
`else
    return q + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start for exactly one edge; returns at the negedge after that edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until done is seen, flagging any cycle where busy drops.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz,
                         input int elat);
    int   lat;
    logic bok;
    issue(a, b);
    wait_done(lat, bok);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy"}, bok & busy, 1'b1);
    check({tag, "_quot"}, quot, eq);
    check({tag, "_rem"}, rem, er);
    check({tag, "_dz"}, div_zero, edz);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_hold"}, {quot, rem}, {eq, er});
  endtask

  initial begin
    int   lat;
    logic bok;
    int   pulses;
    logic leak;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quot", quot, 16'h0);
    check("rst_rem", rem, 16'h0);
    check("rst_dz", div_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, exp_lat(14));
    run_div("d9_0", 16'd9, 16'd0, 16'hFFFF, 16'd9, 1'b1, 0);
    run_div("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, exp_lat(0));
    run_div("dmax_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, exp_lat(65535));

    // A second request in RUN must be ignored and must not change the operands.
    issue(16'd100, 16'd7);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bok);
    check("ign_lat", lat + 3, exp_lat(14));
    check("ign_busy", bok, 1'b1);
    check("ign_res", {quot, rem}, {16'd14, 16'd2});
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("ign_pulses", pulses, 0);

    // Asynchronous reset in the middle of RUN.
    issue(16'd100, 16'd7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out", {quot, rem}, 32'h0);
    check("mid_rst_dz", div_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    leak  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || quot !== 16'h0) leak = 1'b1;
    end
    check("post_rst_quiet", leak, 1'b0);
    run_div("d20_4", 16'd20, 16'd4, 16'd5, 16'd0, 1'b0, exp_lat(5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
